clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of divisor and period counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 100_000_000: divisor loaded at reset (100 MHz to 1 Hz).
REQ-003 SHALL have parameter MIN_DIV, default 2: smallest legal divisor.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_valid  input  1  configuration request.
REQ-007 SHALL have port cfg_ready  output  1  controller can accept a configuration.
REQ-008 SHALL have port cfg_div  input  WIDTH  requested divisor.
REQ-009 SHALL have port cfg_oneshot  input  1  1 = one period then stop; 0 = periodic.
REQ-010 SHALL have port start  input  1  begin counting; ignored unless IDLE.
REQ-011 SHALL have port stop  input  1  abort counting.
REQ-012 SHALL have port tick  output  1  one-cycle pulse at each period end.
REQ-013 SHALL have port clk_out  output  1  divided square wave.
REQ-014 SHALL have port busy  output  1  high in RUN or PENDING.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a one-shot period completes.
REQ-016 SHALL have port cfg_err  output  1  one-cycle pulse when a rejected configuration is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and PENDING; all outputs except cfg_ready and busy SHALL be registered.
REQ-018 SHALL complete a configuration handshake on a rising edge where cfg_valid and cfg_ready are both high.
REQ-019 SHALL drive cfg_ready high in IDLE and RUN, and low in PENDING.
REQ-020 In IDLE, an accepted configuration with cfg_div >= MIN_DIV SHALL load div_active and oneshot_active, effective from the next cycle.
REQ-021 In RUN, an accepted legal configuration SHALL be held in pending registers, moving to PENDING; the current period SHALL finish with the old divisor.
REQ-022 In PENDING, on counter wrap, SHALL emit the tick for the old period, commit the pending divisor and mode, reset the counter to 0 and return to RUN.
REQ-023 An accepted configuration with cfg_div < MIN_DIV SHALL pulse cfg_err for one cycle after the accepting edge, SHALL change no configuration and SHALL leave the state unchanged.
REQ-024 A start sampled in IDLE without stop SHALL clear the counter to 0, set clk_out to 1 and enter RUN.
REQ-025 If cfg and start are sampled on the same edge in IDLE, the counter SHALL start with the new configuration.
REQ-026 In RUN or PENDING, the counter SHALL increment by 1 per cycle and wrap from div_active-1 to 0.
REQ-027 tick SHALL be high for exactly one cycle after the edge on which the counter wraps; the first tick SHALL be high div_active cycles after the start edge.
REQ-028 clk_out SHALL be 1 for counts 0 to floor(div_active/2)-1 and 0 for the rest of the period. Odd divisors SHALL give a shorter high phase.
REQ-029 In one-shot mode, on the first wrap, SHALL pulse tick and done in the same cycle, drive clk_out to 0 and return to IDLE.
REQ-030 In periodic mode, SHALL run until stop; done SHALL remain 0.
REQ-031 A stop sampled in RUN or PENDING SHALL clear the counter and clk_out, enter IDLE and suppress any tick or done due on that edge.
REQ-032 A stop in PENDING SHALL commit the pending configuration to the active registers.
REQ-033 start while busy SHALL be ignored. start and stop on the same edge in IDLE SHALL leave the block in IDLE.
REQ-034 The counter SHALL never exceed div_active-1; arithmetic SHALL be unsigned WIDTH-bit.

Reset
REQ-035 Asserting reset SHALL immediately, without clk, set state IDLE, counter 0, div_active DEFAULT_DIV, oneshot_active 0, pending registers cleared, and tick, clk_out, done and cfg_err 0.
REQ-036 During and after reset, cfg_ready SHALL be 1 and busy SHALL be 0. Reset mid-period SHALL discard the period and any pending configuration.

Verification (bench DEFAULT_DIV=10, WIDTH=32)
REQ-037 SHALL verify periodic operation: reset, then start -> tick pulses 10, 20 and 30 cycles after the start edge; clk_out is high 5 cycles and low 5 cycles per period.
REQ-038 SHALL verify one-shot with an odd divisor: in IDLE, cfg_div=7 and cfg_oneshot=1, then start -> clk_out high 3 cycles and low 4; tick and done coincide at cycle 7; state returns to IDLE and busy=0.
REQ-039 SHALL verify a mid-run reconfiguration: while running div=10, cfg_div=4 at count 3 -> cfg_ready drops; the next tick comes at count 9; the following ticks are 4 cycles apart; cfg_ready returns to 1.
REQ-040 SHALL verify illegal configurations: cfg_div=1 and then cfg_div=0 -> each gives a one-cycle cfg_err pulse; the period stays 10.
REQ-041 SHALL verify stop at wrap: stop on the edge where the counter reaches 9 -> no tick; clk_out=0; busy=0 next cycle.
REQ-042 SHALL verify reset mid-operation: reset asserted asynchronously in PENDING -> outputs clear immediately; the next start runs with div=10.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with a handshaked configuration port.
// It produces a tick pulse at the end of each period and a divided square wave.
// The IDLE/RUN/PENDING FSM lets the divisor change mid-run without truncating
// the current period.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   cfg_valid/cfg_ready configuration handshake (cfg_ready is combinational)
//   cfg_div, cfg_oneshot requested divisor and mode (1 = single period)
//   start, stop         begin counting from IDLE / abort counting
//   tick                one-cycle pulse at each period end (registered)
//   clk_out             divided square wave, high for the first floor(div/2) counts
//   busy                high in RUN or PENDING (combinational)
//   done                one-cycle pulse when a one-shot period completes
//   cfg_err             one-cycle pulse after an accepted divisor below MIN_DIV
module clk_div_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 100_000_000,
  parameter int unsigned MIN_DIV     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             clk_out,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(MIN_DIV);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] div_active, div_nxt;
  logic [WIDTH-1:0] div_pend, div_pend_nxt;
  logic             oneshot_active, oneshot_nxt;
  logic             oneshot_pend, oneshot_pend_nxt;
  logic             tick_nxt, clk_out_nxt, done_nxt, cfg_err_nxt;

  logic             cfg_fire, cfg_take, wrap;
  logic [WIDTH-1:0] cnt_inc;

  // Handshake and status decode
  assign cfg_ready = (state != PENDING);
  assign busy      = (state != IDLE);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_take  = cfg_fire & (cfg_div >= DIV_MIN);
  assign wrap      = (cnt >= (div_active - WIDTH'(1)));
  assign cnt_inc   = cnt + WIDTH'(1);

  // Next-state, counter, configuration and output decode
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    div_nxt          = div_active;
    oneshot_nxt      = oneshot_active;
    div_pend_nxt     = div_pend;
    oneshot_pend_nxt = oneshot_pend;
    tick_nxt         = 1'b0;
    done_nxt         = 1'b0;
    cfg_err_nxt      = cfg_fire & ~cfg_take;
    clk_out_nxt      = 1'b0;

    case (state)
      IDLE: begin
        // Loading before the start check lets cfg+start run with the new divisor
        if (cfg_take) begin
          div_nxt     = cfg_div;
          oneshot_nxt = cfg_oneshot;
        end
        if (start && !stop) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end

      RUN: begin
        if (stop || (wrap && oneshot_active)) begin
          // Run ends here: a config arriving on this edge becomes active directly
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (cfg_take) begin
            div_nxt     = cfg_div;
            oneshot_nxt = cfg_oneshot;
          end
          if (!stop) begin
            tick_nxt = 1'b1;
            done_nxt = 1'b1;
          end
        end else begin
          cnt_nxt  = wrap ? '0 : cnt_inc;
          tick_nxt = wrap;
          // New divisor waits for the end of the period that follows this edge
          if (cfg_take) begin
            div_pend_nxt     = cfg_div;
            oneshot_pend_nxt = cfg_oneshot;
            state_nxt        = PENDING;
          end
        end
      end

      PENDING: begin
        if (stop) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          div_nxt     = div_pend;
          oneshot_nxt = oneshot_pend;
        end else if (wrap) begin
          tick_nxt    = 1'b1;
          cnt_nxt     = '0;
          div_nxt     = div_pend;
          oneshot_nxt = oneshot_pend;
          // A one-shot period still completes under its own mode
          if (oneshot_active) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Square wave follows the count and divisor that hold after this edge
    if (state_nxt != IDLE) begin
      clk_out_nxt = (cnt_nxt < (div_nxt >> 1));
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      div_active     <= DIV_RST;
      oneshot_active <= 1'b0;
      div_pend       <= '0;
      oneshot_pend   <= 1'b0;
      tick           <= 1'b0;
      clk_out        <= 1'b0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      div_active     <= div_nxt;
      oneshot_active <= oneshot_nxt;
      div_pend       <= div_pend_nxt;
      oneshot_pend   <= oneshot_pend_nxt;
      tick           <= tick_nxt;
      clk_out        <= clk_out_nxt;
      done           <= done_nxt;
      cfg_err        <= cfg_err_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: testbench for clk_div_ctrl (WIDTH=32, DEFAULT_DIV=10, MIN_DIV=2).
// Output vector order in checks: {cfg_ready, busy, tick, clk_out, done, cfg_err}.
module tb_clk_div_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_div = '0;
  logic        cfg_oneshot = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tick, clk_out, busy, done, cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  clk_div_ctrl #(.WIDTH(32), .DEFAULT_DIV(10), .MIN_DIV(2)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
    .tick(tick), .clk_out(clk_out), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [31:0] dv;
    logic        one;
    logic        st;
    logic        sp;
    logic [5:0]  exp;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic cv, logic [31:0] dv, logic one, logic st, logic sp,
                              logic [5:0] exp);
    vec_t v;
    v.cv = cv; v.dv = dv; v.one = one; v.st = st; v.sp = sp; v.exp = exp;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {cfg_ready, busy, tick, clk_out, done, cfg_err};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; cfg_div = '0; cfg_oneshot = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Steps until tick is seen; n = cycles taken, or -1 when the budget runs out
  task automatic wait_tick(input int max_cycles, output int n);
    n = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      step();
      if (tick === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  // Reference model: period age, active/queued configuration, run flag
  bit          m_busy, m_pend, m_one, p_one;
  int unsigned m_div, p_div, m_age;
  bit          e_tick, e_done, e_err;

  function automatic void model_reset();
    m_busy = 0; m_pend = 0; m_one = 0; p_one = 0;
    m_div = 10; p_div = 0; m_age = 0;
    e_tick = 0; e_done = 0; e_err = 0;
  endfunction

  function automatic void model_edge(bit cv, int unsigned dv, bit one, bit st, bit sp);
    bit fire, take, ends;
    fire   = cv && !m_pend;
    take   = fire && (dv >= 2);
    e_err  = fire && !take;
    e_tick = 0;
    e_done = 0;
    if (!m_busy) begin
      if (take) begin m_div = dv; m_one = one; end
      if (st && !sp) begin m_busy = 1; m_age = 0; end
    end else begin
      ends = (m_age + 1 == m_div);
      if (sp || (ends && m_one)) begin
        if (m_pend) begin m_div = p_div; m_one = p_one; m_pend = 0; end
        else if (take) begin m_div = dv; m_one = one; end
        if (!sp) begin e_tick = 1; e_done = 1; end
        m_busy = 0;
        m_age  = 0;
      end else if (ends) begin
        e_tick = 1;
        m_age  = 0;
        if (m_pend) begin m_div = p_div; m_one = p_one; m_pend = 0; end
        else if (take) begin p_div = dv; p_one = one; m_pend = 1; end
      end else begin
        m_age++;
        if (take) begin p_div = dv; p_one = one; m_pend = 1; end
      end
    end
  endfunction

  function automatic logic [5:0] model_outs();
    return {!m_pend, m_busy, e_tick, m_busy && (m_age < m_div / 2), e_done, e_err};
  endfunction

  initial begin
    int n;
    int tq[$];
    int hi [3];

    // Vector table: illegal configs, start+stop, then a one-shot divide-by-7
    tbl[0]  = mk(1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 6'b100001);
    tbl[1]  = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 6'b100000);
    tbl[2]  = mk(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 6'b100001);
    tbl[3]  = mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 6'b100000);
    tbl[4]  = mk(1'b1, 32'd7, 1'b1, 1'b0, 1'b0, 6'b100000);
    tbl[5]  = mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 6'b110100);
    tbl[6]  = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 6'b110100);
    tbl[7]  = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 6'b110100);
    for (int k = 8; k <= 11; k++) tbl[k] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 6'b110000);
    tbl[12] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 6'b101010);
    tbl[13] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 6'b100000);

    // Asynchronous reset, observed before any clock edge
    #1 reset = 1'b1;
    #1 check("reset_async", 32'(outs()), 32'(6'b100000));
    do_reset();
    check("reset_release", 32'(outs()), 32'(6'b100000));

    for (int k = 0; k < 14; k++) begin
      cfg_valid = tbl[k].cv; cfg_div = tbl[k].dv; cfg_oneshot = tbl[k].one;
      start = tbl[k].st; stop = tbl[k].sp;
      step();
      check($sformatf("tbl[%0d]", k), 32'(outs()), 32'(tbl[k].exp));
    end
    idle_inputs();

    // Periodic divide-by-10: ticks at 10/20/30, 5 high + 5 low per period
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    hi[0] = int'(clk_out); hi[1] = 0; hi[2] = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (tick === 1'b1) tq.push_back(c);
      if (c < 30) hi[c / 10] += int'(clk_out);
    end
    check("per_tick_count", 32'(tq.size()), 32'd3);
    check("per_tick0", 32'(tq.size() > 0 ? tq[0] : -1), 32'd10);
    check("per_tick1", 32'(tq.size() > 1 ? tq[1] : -1), 32'd20);
    check("per_tick2", 32'(tq.size() > 2 ? tq[2] : -1), 32'd30);
    for (int p = 0; p < 3; p++) check($sformatf("per_high%0d", p), 32'(hi[p]), 32'd5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("per_stopped", 32'(outs()), 32'(6'b100000));

    // Mid-run reconfiguration to 4 at count 3
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    cfg_valid = 1'b1; cfg_div = 32'd4;
    step();
    idle_inputs();
    check("recfg_ready_low", 32'(cfg_ready), 32'd0);
    wait_tick(20, n);
    check("recfg_first_tick", 32'(n), 32'd6);
    check("recfg_ready_back", 32'(cfg_ready), 32'd1);
    wait_tick(20, n);
    check("recfg_tick_gap1", 32'(n), 32'd4);
    wait_tick(20, n);
    check("recfg_tick_gap2", 32'(n), 32'd4);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Stop on the wrap edge suppresses the tick
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stopwrap_outs", 32'(outs()), 32'(6'b100000));

    // Reset asserted asynchronously while PENDING
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    cfg_valid = 1'b1; cfg_div = 32'd4;
    step();
    idle_inputs();
    check("rst_pending_entered", 32'(cfg_ready), 32'd0);
    #2 reset = 1'b1;
    #1 check("rst_mid_outs", 32'(outs()), 32'(6'b100000));
    #2 reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_tick(30, n);
    check("rst_mid_period", 32'(n), 32'd10);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Randomized stimulus against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      cfg_valid   = ($urandom_range(0, 7) == 0);
      cfg_div     = 32'($urandom_range(0, 12));
      cfg_oneshot = ($urandom_range(0, 3) == 0);
      start       = ($urandom_range(0, 3) == 0);
      stop        = ($urandom_range(0, 29) == 0);
      step();
      model_edge(cfg_valid, cfg_div, cfg_oneshot, start, stop);
      check($sformatf("rand[%0d]", i), 32'(outs()), 32'(model_outs()));
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
